// File: rtl/multicycle_core_pkg.sv
// Shared types and RV32I encoding constants for the multicycle core.
package multicycle_core_pkg;

   // Control FSM states; one instruction walks Fetch -> Decode -> Execute -> Writeback.
   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExecute,
      StWriteback,
      StHalt
   } state_e;

   // ALU operations needed by the supported subset.
   typedef enum logic [1:0] {
      AluAdd,
      AluSub,
      AluPassB
   } alu_op_e;

   // Major opcodes.
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcBranch = 7'b1100011;

   // funct3 values.
   localparam logic [2:0] F3AddSub = 3'b000;
   localparam logic [2:0] F3Beq    = 3'b000;
   localparam logic [2:0] F3Bne    = 3'b001;

   // funct7 values for register-register ops.
   localparam logic [6:0] F7Add = 7'b0000000;
   localparam logic [6:0] F7Sub = 7'b0100000;

   // Reassemble the scattered B-type offset (bit 0 is always zero).
   function automatic logic [12:0] b_offset(logic [31:0] ir);
      return {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// x0 is never written, so it always reads zero.
module mc_regfile
   import multicycle_core_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [$clog2(NUM_REGS)-1:0] raddr1,
   output logic [DATA_WIDTH-1:0]       rdata1,
   input  logic [$clog2(NUM_REGS)-1:0] raddr2,
   output logic [DATA_WIDTH-1:0]       rdata2,
   input  logic                        we,
   input  logic [$clog2(NUM_REGS)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]       wdata,
   output logic [DATA_WIDTH-1:0]       x10
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   // Clear on reset; discard writes that target x0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata1 = regs_q[raddr1];
   assign rdata2 = regs_q[raddr2];
   assign x10    = regs_q[10];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core (ADDI, ADD, SUB, LUI, BEQ, BNE).
// Each instruction takes Fetch (1+ cycles), Decode, Execute and Writeback.
// Any unsupported encoding parks the core in a sticky halt until reset.
module multicycle_core
   import multicycle_core_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned NUM_REGS      = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic                     imem_valid,
   input  logic [31:0]              imem_rdata,
   output logic [DATA_WIDTH-1:0]    a0,
   output logic                     retired,
   output logic                     halted
);

   localparam int unsigned IdxW = $clog2(NUM_REGS);

   state_e state_q, state_d;

   logic [ADDRESS_WIDTH-1:0] pc_q;
   logic [31:0]              ir_q;
   logic [DATA_WIDTH-1:0]    op_a_q, op_b_q, alu_q;
   logic                     taken_q;

   // Instruction fields; upper register-index bits are dropped for small register files.
   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [IdxW-1:0] rs1, rs2, rd;

   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];
   assign funct7 = ir_q[31:25];
   assign rd     = ir_q[7 +: IdxW];
   assign rs1    = ir_q[15 +: IdxW];
   assign rs2    = ir_q[20 +: IdxW];

   // Sign-extended immediates.
   logic [DATA_WIDTH-1:0]    imm_i, imm_u;
   logic [ADDRESS_WIDTH-1:0] br_off;

   assign imm_i  = DATA_WIDTH'($signed(ir_q[31:20]));
   assign imm_u  = DATA_WIDTH'($signed({ir_q[31:12], 12'b0}));
   assign br_off = ADDRESS_WIDTH'($signed(b_offset(ir_q)));

   // Decoded control; IR is stable from Decode to Writeback so this stays combinational.
   logic                  dec_legal, dec_use_imm, dec_wr, dec_branch, dec_bne;
   alu_op_e               dec_alu_op;
   logic [DATA_WIDTH-1:0] dec_imm;

   // Decode the instruction word into control signals and a legality flag.
   always_comb begin
      dec_legal   = 1'b0;
      dec_use_imm = 1'b0;
      dec_wr      = 1'b0;
      dec_branch  = 1'b0;
      dec_bne     = 1'b0;
      dec_alu_op  = AluAdd;
      dec_imm     = imm_i;
      case (opcode)
         OpcOpImm: begin
            if (funct3 == F3AddSub) begin
               dec_legal   = 1'b1;
               dec_use_imm = 1'b1;
               dec_wr      = 1'b1;
            end
         end
         OpcOp: begin
            if (funct3 == F3AddSub && funct7 == F7Add) begin
               dec_legal = 1'b1;
               dec_wr    = 1'b1;
            end else if (funct3 == F3AddSub && funct7 == F7Sub) begin
               dec_legal  = 1'b1;
               dec_wr     = 1'b1;
               dec_alu_op = AluSub;
            end
         end
         OpcLui: begin
            dec_legal   = 1'b1;
            dec_use_imm = 1'b1;
            dec_wr      = 1'b1;
            dec_imm     = imm_u;
            dec_alu_op  = AluPassB;
         end
         OpcBranch: begin
            if (funct3 == F3Beq || funct3 == F3Bne) begin
               dec_legal  = 1'b1;
               dec_branch = 1'b1;
               dec_bne    = (funct3 == F3Bne);
            end
         end
         default: ;
      endcase
   end

   // Register file hookup.
   logic [DATA_WIDTH-1:0] rf_rdata1, rf_rdata2;
   logic                  rf_we;

   assign rf_we = (state_q == StWriteback) && dec_wr;

   mc_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (rs1),
      .rdata1 (rf_rdata1),
      .raddr2 (rs2),
      .rdata2 (rf_rdata2),
      .we     (rf_we),
      .waddr  (rd),
      .wdata  (alu_q),
      .x10    (a0)
   );

   // ALU and branch comparison on the latched operands; results wrap.
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  br_cond;

   always_comb begin
      alu_res = '0;
      unique case (dec_alu_op)
         AluAdd:   alu_res = op_a_q + op_b_q;
         AluSub:   alu_res = op_a_q - op_b_q;
         AluPassB: alu_res = op_b_q;
         default:  alu_res = '0;
      endcase
      br_cond = dec_bne ? (op_a_q != op_b_q) : (op_a_q == op_b_q);
   end

   // Datapath registers, each loaded in the state that produces it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= '0;
         ir_q    <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         alu_q   <= '0;
         taken_q <= 1'b0;
      end else begin
         case (state_q)
            StFetch: begin
               if (imem_valid) begin
                  ir_q <= imem_rdata;
               end
            end
            StDecode: begin
               op_a_q <= rf_rdata1;
               op_b_q <= dec_use_imm ? dec_imm : rf_rdata2;
            end
            StExecute: begin
               alu_q   <= alu_res;
               taken_q <= dec_branch && br_cond;
            end
            StWriteback: begin
               pc_q <= taken_q ? (pc_q + br_off) : (pc_q + ADDRESS_WIDTH'(4));
            end
            default: ;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake/status outputs.
   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      retired  = 1'b0;
      halted   = 1'b0;
      unique case (state_q)
         StFetch: begin
            // Gate with reset so no request is visible while reset is held.
            imem_req = rst;
            if (imem_valid) begin
               state_d = StDecode;
            end
         end
         StDecode:    state_d = dec_legal ? StExecute : StHalt;
         StExecute:   state_d = StWriteback;
         StWriteback: begin
            retired = 1'b1;
            state_d = StFetch;
         end
         StHalt:      halted = 1'b1;
         default:     state_d = StFetch;
      endcase
   end

   assign imem_addr = pc_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: an instruction-level reference model
// predicts every retirement, a monitor checks them as the core retires.
module tb_multicycle_core;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_valid = 1'b0;
   logic [31:0]   imem_rdata = '0;
   logic [DW-1:0] a0;
   logic          retired;
   logic          halted;

   multicycle_core #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .NUM_REGS      (NR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .a0         (a0),
      .retired    (retired),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input bit ok, input string name, input logic [63:0] act,
                        input logic [63:0] req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Instruction memory and expected-retirement scoreboard.
   logic [31:0] mem [64];

   typedef struct {
      logic [AW-1:0] pc;
      logic [DW-1:0] a0;
   } exp_t;

   exp_t          exp_q[$];
   logic [AW-1:0] exp_pc;
   logic [DW-1:0] exp_a0;
   int            exp_cnt;

   // Encoders.
   function automatic logic [31:0] i_t(input int rd, input int rs1, input int imm);
      logic [11:0] im;
      im = imm[11:0];
      return {im, 5'(rs1), 3'b000, 5'(rd), 7'h13};
   endfunction

   function automatic logic [31:0] r_t(input logic [6:0] f7, input int rd, input int rs1,
                                       input int rs2);
      return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] u_t(input int rd, input int imm20);
      logic [19:0] im;
      im = imm20[19:0];
      return {im, 5'(rd), 7'h37};
   endfunction

   function automatic logic [31:0] b_t(input logic [2:0] f3, input int rs1, input int rs2,
                                       input int off);
      logic [12:0] o;
      o = off[12:0];
      return {o[12], o[10:5], 5'(rs2), 5'(rs1), f3, o[4:1], o[11], 7'h63};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
   endtask

   // Reference model: executes the program one instruction at a time until an
   // illegal word, pushing the PC and resulting x10 for every retirement.
   task automatic iss();
      logic [31:0]        r [32];
      logic [AW-1:0]      pc, nxt;
      logic [31:0]        w, res;
      logic signed [31:0] sw;
      logic signed [12:0] bo;
      logic [6:0]         opc, f7;
      logic [2:0]         f3;
      int                 rd, rs1, rs2, n;
      bit                 stop, wr;
      exp_t               e;
      for (int i = 0; i < 32; i++) r[i] = '0;
      pc = '0;
      n = 0;
      stop = 0;
      exp_q.delete();
      while (!stop && n < 1000) begin
         w   = mem[pc[7:2]];
         sw  = w;
         opc = w[6:0];
         f3  = w[14:12];
         f7  = w[31:25];
         rd  = int'(w[11:7]);
         rs1 = int'(w[19:15]);
         rs2 = int'(w[24:20]);
         nxt = pc + 16'd4;
         wr  = 0;
         res = '0;
         if (opc == 7'h13 && f3 == 3'd0) begin
            res = r[rs1] + 32'(sw >>> 20);
            wr = 1;
         end else if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
            res = r[rs1] + r[rs2];
            wr = 1;
         end else if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
            res = r[rs1] - r[rs2];
            wr = 1;
         end else if (opc == 7'h37) begin
            res = {w[31:12], 12'h000};
            wr = 1;
         end else if (opc == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
            bo = {w[31], w[7], w[30:25], w[11:8], 1'b0};
            if ((f3 == 3'd0) == (r[rs1] == r[rs2])) nxt = pc + {{(AW-13){bo[12]}}, bo};
         end else begin
            stop = 1;
         end
         if (!stop) begin
            if (wr && rd != 0) r[rd] = res;
            n++;
            e.pc = pc;
            e.a0 = r[10];
            exp_q.push_back(e);
            pc = nxt;
         end
      end
      exp_pc  = pc;
      exp_a0  = r[10];
      exp_cnt = n;
   endtask

   // Memory responder: per-fetch stall (fixed or random), address-stability check.
   int            stall_mode  = 0;
   int            stall_left  = 0;
   int            cur_stall   = 0;
   int            last_stall  = 0;
   bit            in_fetch    = 0;
   bit            force_valid = 0;
   logic [31:0]   force_word  = '0;
   logic [AW-1:0] hold_addr   = '1;
   logic [AW-1:0] fetch_addr  = '0;

   always @(negedge clk) begin
      imem_valid = 1'b0;
      if (force_valid) begin
         imem_valid = 1'b1;
         imem_rdata = force_word;
      end else if (imem_req) begin
         if (!in_fetch) begin
            in_fetch   = 1;
            fetch_addr = imem_addr;
            if (imem_addr == hold_addr) stall_left = 1000000;
            else if (stall_mode < 0) stall_left = int'($urandom_range(0, 3));
            else stall_left = stall_mode;
            cur_stall = stall_left;
         end else begin
            check(imem_addr == fetch_addr, "addr_stable", imem_addr, fetch_addr);
         end
         if (stall_left == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem[imem_addr[7:2]];
            last_stall = cur_stall;
            in_fetch   = 0;
         end else begin
            stall_left--;
         end
      end else begin
         in_fetch = 0;
      end
   end

   // Monitor: pops one expectation per retire pulse, checks PC, a0 one cycle
   // later, and the spacing between retirements.
   int            cyc      = 0;
   int            last_ret = -1;
   int            n_ret    = 0;
   bit            a0_pend  = 0;
   logic [DW-1:0] a0_exp   = '0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         a0_pend  = 0;
         last_ret = -1;
         n_ret    = 0;
      end else begin
         if (a0_pend) begin
            check(a0 == a0_exp, "a0_after_wb", a0, a0_exp);
            a0_pend = 0;
         end
         if (retired) begin
            n_ret++;
            check(exp_q.size() != 0, "retire_expected", n_ret, exp_cnt);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check(imem_addr == e.pc, "retire_pc", imem_addr, e.pc);
               a0_exp  = e.a0;
               a0_pend = 1;
            end
            if (last_ret >= 0) begin
               check(cyc - last_ret == 4 + last_stall, "retire_gap", cyc - last_ret,
                     4 + last_stall);
            end
            last_ret = cyc;
         end
      end
   end

   // Reset, model the loaded program, release reset and check the first request.
   task automatic start(input int smode);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check(imem_req == 1'b0, "rst_req", imem_req, 0);
      check(imem_addr == '0, "rst_pc", imem_addr, 0);
      check(a0 == '0, "rst_a0", a0, 0);
      check(halted == 1'b0, "rst_halted", halted, 0);
      check(retired == 1'b0, "rst_retired", retired, 0);
      iss();
      stall_mode = smode;
      #2 rst = 1'b1;
      #1;
      check(imem_req == 1'b1, "req_after_release", imem_req, 1);
      check(imem_addr == '0, "first_fetch_addr", imem_addr, 0);
   endtask

   // Wait (bounded) for the halt, poke imem_valid, then check the frozen state.
   task automatic wait_halt(input string tag);
      logic [DW-1:0] a0_hold;
      for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
      check(halted == 1'b1, {tag, "/halt_reached"}, halted, 1);
      a0_hold = exp_a0;
      force_word = 32'h06300513;
      force_valid = 1;
      @(negedge clk);
      @(negedge clk);
      force_valid = 0;
      repeat (4) @(negedge clk);
      check(halted == 1'b1, {tag, "/halt_sticky"}, halted, 1);
      check(imem_req == 1'b0, {tag, "/halt_req"}, imem_req, 0);
      check(retired == 1'b0, {tag, "/halt_retired"}, retired, 0);
      check(a0 == a0_hold, {tag, "/final_a0"}, a0, a0_hold);
      check(imem_addr == exp_pc, {tag, "/halt_pc"}, imem_addr, exp_pc);
      check(n_ret == exp_cnt, {tag, "/retire_count"}, n_ret, exp_cnt);
      check(exp_q.size() == 0, {tag, "/queue_drained"}, exp_q.size(), 0);
   endtask

   task automatic gen_random(input int len);
      int k, rd, rs1, rs2;
      clear_mem();
      for (int i = 0; i < len; i++) begin
         k   = int'($urandom_range(0, 15));
         rd  = ($urandom_range(0, 2) == 0) ? 10 : int'($urandom_range(0, 31));
         rs1 = int'($urandom_range(0, 12));
         rs2 = int'($urandom_range(0, 12));
         if (k < 5) mem[i] = i_t(rd, rs1, int'($urandom_range(0, 4095)) - 2048);
         else if (k < 8) mem[i] = r_t(7'h00, rd, rs1, rs2);
         else if (k < 10) mem[i] = r_t(7'h20, rd, rs1, rs2);
         else if (k < 12) mem[i] = u_t(rd, int'($urandom_range(0, 20'hFFFFF)));
         else if (k < 15) mem[i] = b_t(3'($urandom_range(0, 1)), rs1, rs2, 8);
         else mem[i] = r_t(7'h01, rd, rs1, rs2);
      end
   endtask

   initial begin
      // Two ADDIs then an illegal zero word at PC=8.
      clear_mem();
      mem[0] = i_t(10, 0, 5);
      mem[1] = i_t(10, 10, -7);
      start(0);
      wait_halt("addi_pair");
      check(a0 == 32'hFFFF_FFFE, "addi_pair_a0", a0, 32'hFFFF_FFFE);
      check(n_ret == 2, "addi_pair_count", n_ret, 2);

      // Same program with three stall cycles on every fetch.
      start(3);
      wait_halt("stall3");

      // Countdown loop with a backward BNE.
      clear_mem();
      mem[0] = i_t(5, 0, 3);
      mem[1] = i_t(10, 10, 1);
      mem[2] = i_t(5, 5, -1);
      mem[3] = b_t(3'b001, 5, 0, -8);
      start(0);
      wait_halt("loop");
      check(a0 == 32'd3, "loop_a0", a0, 3);
      check(imem_addr == 16'd16, "loop_pc", imem_addr, 16);
      check(n_ret == 10, "loop_count", n_ret, 10);

      // Writes to x0 are discarded.
      clear_mem();
      mem[0] = i_t(10, 0, 7);
      mem[1] = i_t(0, 0, 9);
      mem[2] = r_t(7'h00, 10, 0, 0);
      start(-1);
      wait_halt("x0");
      check(a0 == '0, "x0_a0", a0, 0);

      // Random programs with random fetch stalls.
      for (int t = 0; t < 12; t++) begin
         gen_random(int'($urandom_range(6, 14)));
         start(-1);
         wait_halt("rand");
      end

      // Reset asserted while a fetch is stalled, with imem_valid pulsed during reset.
      clear_mem();
      mem[0] = i_t(10, 0, 5);
      mem[1] = i_t(10, 10, 2);
      hold_addr = 16'd4;
      start(0);
      for (int i = 0; i < 60 && !(n_ret == 1 && imem_req && imem_addr == 16'd4); i++) begin
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check(a0 == 32'd5, "stall_a0", a0, 5);
      check(imem_req == 1'b1, "stall_req", imem_req, 1);
      check(imem_addr == 16'd4, "stall_addr", imem_addr, 4);
      #2 rst = 1'b0;
      #1;
      check(imem_req == 1'b0, "midrst_req", imem_req, 0);
      check(imem_addr == '0, "midrst_pc", imem_addr, 0);
      check(a0 == '0, "midrst_a0", a0, 0);
      check(halted == 1'b0, "midrst_halted", halted, 0);
      hold_addr   = '1;
      force_word  = i_t(10, 0, 99);
      force_valid = 1;
      @(negedge clk);
      #1 check(imem_req == 1'b0, "late_valid_req", imem_req, 0);
      @(negedge clk);
      force_valid = 0;
      start(0);
      wait_halt("rerun");
      check(a0 == 32'd7, "rerun_a0", a0, 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register/ALU width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 16, PC and instruction-address width.
REQ-003 SHALL have parameter NUM_REGS, default 32, register count; legal values 16 or 32; x0 reads zero.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 imem_req  out  1  fetch request, held high until imem_valid.
REQ-007 imem_addr  out  ADDRESS_WIDTH  byte address of the instruction (PC).
REQ-008 imem_valid  in  1  imem_rdata valid this cycle; ignored unless imem_req is high.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 a0  out  DATA_WIDTH  current value of register x10.
REQ-011 retired  out  1  one-cycle pulse per completed instruction.
REQ-012 halted  out  1  sticky; high after an illegal instruction.

Function
REQ-013 SHALL implement FSM states FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-014 FETCH: imem_req=1, imem_addr=PC; on imem_valid latch imem_rdata into IR and go to DECODE; otherwise stay in FETCH, with no limit on the wait.
REQ-015 DECODE: read rs1/rs2 into operand latches; sign-extend the I/B/U immediate to DATA_WIDTH; an illegal opcode/funct goes to HALT, otherwise to EXECUTE.
REQ-016 Supported instructions: ADDI, ADD, SUB, LUI, BEQ, BNE (RV32I encodings); all others are illegal.
REQ-017 EXECUTE: ALU result computed modulo 2^DATA_WIDTH (wrap, no flags); branch condition evaluated on the full DATA_WIDTH operands.
REQ-018 WRITEBACK: write rd if the instruction writes and rd!=0; PC <= PC+B-imm if the branch is taken, else PC+4; retired=1 for this cycle; next state FETCH.
REQ-019 PC arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-020 Register index bits beyond log2(NUM_REGS) SHALL be ignored; a write to x0 SHALL be discarded.
REQ-021 Minimum latency SHALL be 4 cycles per instruction (imem_valid in the first FETCH cycle); each imem stall cycle adds one cycle.
REQ-022 HALT: imem_req=0, retired=0, halted=1; stays until reset; register file frozen; a0 holds its value.
REQ-023 A register written in WRITEBACK SHALL be visible to the next instruction's DECODE (no hazard logic needed).
REQ-024 a0 SHALL update in the cycle after the WRITEBACK that targets x10.

Reset
REQ-025 Asserting rst SHALL immediately force: state=FETCH, PC=0, IR=0, all registers 0, a0=0, retired=0, halted=0.
REQ-026 While rst is low imem_req SHALL be 0; the first request is issued in the first clk edge-cycle after rst deasserts.
REQ-027 Reset mid-fetch SHALL abandon the outstanding request; a late imem_valid after reset, when imem_req=0, SHALL be ignored.

Structure
REQ-028 Package multicycle_core_pkg SHALL hold the state enum, opcode/funct3/funct7 constants and the ALU-op enum.
REQ-029 The register file SHALL be a sub-module mc_regfile (parametrised DATA_WIDTH/NUM_REGS, 2 async read ports, 1 sync write port, async active-low reset).
REQ-030 The FSM, immediate generation, ALU and PC logic SHALL live in multicycle_core.

Verification
REQ-031 Program ADDI x10,x0,5; ADDI x10,x10,-7 with imem_valid always 1 -> a0=5 then 0xFFFFFFFE; retired pulses 4 cycles apart.
REQ-032 Loop ADDI x5,x0,3; ADDI x10,x10,1; ADDI x5,x5,-1; BNE x5,x0,-8 -> ends with a0=3, BNE taken twice, then PC=16.
REQ-033 ADDI x0,x0,9 then ADD x10,x0,x0 -> a0=0.
REQ-034 imem_valid delayed 3 cycles on every fetch -> each instruction takes 7 cycles; imem_addr stable while imem_req is high.
REQ-035 Illegal word 0x00000000 at PC=8 -> halted=1 and imem_req=0 permanently; a0 unchanged; retired count=2.
REQ-036 rst asserted during a FETCH stall, with imem_valid pulsed afterwards -> PC=0, a0=0, imem_req=0 until rst is released; the next fetch is from address 0.
